// File: rtl/tmds_channel_encoder.sv
// Multi-lane TMDS encoder: control, DC-balanced video, TERC4 and guard bands.
// Two-stage pipeline with one running-disparity counter per lane.
//
// Ports:
//   clk_i    pixel clock
//   rst_n_i  asynchronous active-low reset
//   mode_i   0 ctrl, 1 video, 2 TERC4, 3 video guard, 4 data guard, 5-7 ctrl
//   data_i   8 bits per lane, video byte
//   ctrl_i   2 bits per lane, {c1,c0}
//   terc4_i  4 bits per lane, TERC4 nibble
//   data_o   10 bits per lane, encoded symbol (bit 9 sent last)
//   disp_o   CNT_W bits per lane, signed running disparity after data_o
module tmds_channel_encoder #(
    parameter int CHANNELS = 3,
    parameter int CNT_W    = 5
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic [2:0]                mode_i,
    input  logic [8*CHANNELS-1:0]     data_i,
    input  logic [2*CHANNELS-1:0]     ctrl_i,
    input  logic [4*CHANNELS-1:0]     terc4_i,
    output logic [10*CHANNELS-1:0]    data_o,
    output logic [CNT_W*CHANNELS-1:0] disp_o
);

    localparam logic [2:0] MODE_CTRL   = 3'd0;
    localparam logic [2:0] MODE_VIDEO  = 3'd1;
    localparam logic [2:0] MODE_TERC4  = 3'd2;
    localparam logic [2:0] MODE_VGUARD = 3'd3;
    localparam logic [2:0] MODE_DGUARD = 3'd4;

    localparam logic [9:0] CTRL_00  = 10'b1101010100;
    localparam logic [9:0] CTRL_01  = 10'b0010101011;
    localparam logic [9:0] CTRL_10  = 10'b0101010100;
    localparam logic [9:0] CTRL_11  = 10'b1010101011;
    localparam logic [9:0] GUARD_HI = 10'b1011001100;
    localparam logic [9:0] GUARD_LO = 10'b0100110011;

    localparam logic signed [CNT_W-1:0] EIGHT = CNT_W'(8);
    localparam logic signed [CNT_W-1:0] TWO   = CNT_W'(2);

    function automatic logic [3:0] ones8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    // Transition-minimising stage; bit 8 records XOR (1) vs XNOR (0).
    function automatic logic [8:0] qm_of(input logic [7:0] b);
        logic [8:0] q;
        logic [3:0] n;
        logic       use_xnor;
        n        = ones8(b);
        use_xnor = (n > 4'd4) || ((n == 4'd4) && !b[0]);
        q[0]     = b[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = use_xnor ? ~(q[i-1] ^ b[i]) : (q[i-1] ^ b[i]);
        end
        q[8] = ~use_xnor;
        return q;
    endfunction

    function automatic logic [9:0] ctrl_code(input logic [1:0] c);
        logic [9:0] s;
        case (c)
            2'b00:   s = CTRL_00;
            2'b01:   s = CTRL_01;
            2'b10:   s = CTRL_10;
            default: s = CTRL_11;
        endcase
        return s;
    endfunction

    function automatic logic [9:0] terc4_code(input logic [3:0] nib);
        logic [9:0] s;
        case (nib)
            4'h0:    s = 10'b1010011100;
            4'h1:    s = 10'b1001100011;
            4'h2:    s = 10'b1011100100;
            4'h3:    s = 10'b1011100010;
            4'h4:    s = 10'b0101110001;
            4'h5:    s = 10'b0100011110;
            4'h6:    s = 10'b0110001110;
            4'h7:    s = 10'b0100111100;
            4'h8:    s = 10'b1011001100;
            4'h9:    s = 10'b0100111001;
            4'hA:    s = 10'b0110011100;
            4'hB:    s = 10'b1011000110;
            4'hC:    s = 10'b1010001110;
            4'hD:    s = 10'b1001110001;
            4'hE:    s = 10'b0101100011;
            default: s = 10'b1011000011;
        endcase
        return s;
    endfunction

    // DC-balance stage: returns {symbol, next disparity}.
    function automatic logic [10+CNT_W-1:0] video_enc(
        input logic [8:0]              qm,
        input logic [3:0]              n1,
        input logic signed [CNT_W-1:0] cnt
    );
        logic signed [CNT_W-1:0] d;
        logic signed [CNT_W-1:0] q8x2;
        logic signed [CNT_W-1:0] nq8x2;
        logic signed [CNT_W-1:0] nxt;
        logic [9:0]              sym;
        d     = $signed(CNT_W'({n1, 1'b0})) - EIGHT;
        q8x2  = qm[8] ? TWO : '0;
        nq8x2 = qm[8] ? '0 : TWO;
        if ((cnt == '0) || (d == '0)) begin
            if (qm[8]) begin
                sym = {2'b01, qm[7:0]};
                nxt = cnt + d;
            end else begin
                sym = {2'b10, ~qm[7:0]};
                nxt = cnt - d;
            end
        end else if (cnt[CNT_W-1] == d[CNT_W-1]) begin
            // Disparity would grow further: invert the payload.
            sym = {1'b1, qm[8], ~qm[7:0]};
            nxt = cnt + q8x2 - d;
        end else begin
            sym = {1'b0, qm[8], qm[7:0]};
            nxt = cnt - nq8x2 + d;
        end
        return {sym, nxt};
    endfunction

    logic [2:0]                s1_mode;
    logic [2*CHANNELS-1:0]     s1_ctrl;
    logic [4*CHANNELS-1:0]     s1_terc4;
    logic [9*CHANNELS-1:0]     s1_qm;
    logic [4*CHANNELS-1:0]     s1_n1;
    logic [9*CHANNELS-1:0]     qm_d;
    logic [4*CHANNELS-1:0]     n1_d;
    logic [10*CHANNELS-1:0]    sym_d;
    logic [CNT_W*CHANNELS-1:0] cnt_d;
    logic [CNT_W*CHANNELS-1:0] cnt_q;

    always_comb begin
        qm_d = '0;
        n1_d = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            qm_d[k*9 +: 9] = qm_of(data_i[k*8 +: 8]);
            n1_d[k*4 +: 4] = ones8(qm_d[k*9 +: 8]);
        end
    end

    always_comb begin
        sym_d = '0;
        cnt_d = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            case (s1_mode)
                MODE_VIDEO: begin
                    {sym_d[k*10 +: 10], cnt_d[k*CNT_W +: CNT_W]} =
                        video_enc(s1_qm[k*9 +: 9], s1_n1[k*4 +: 4],
                                  $signed(cnt_q[k*CNT_W +: CNT_W]));
                end
                MODE_TERC4: begin
                    sym_d[k*10 +: 10] = terc4_code(s1_terc4[k*4 +: 4]);
                end
                MODE_VGUARD: begin
                    sym_d[k*10 +: 10] = (k % 3 == 1) ? GUARD_LO : GUARD_HI;
                end
                MODE_DGUARD: begin
                    sym_d[k*10 +: 10] = (k % 3 == 0) ?
                        terc4_code(s1_terc4[k*4 +: 4]) : GUARD_LO;
                end
                default: begin
                    sym_d[k*10 +: 10] = ctrl_code(s1_ctrl[k*2 +: 2]);
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_mode  <= MODE_CTRL;
            s1_ctrl  <= '0;
            s1_terc4 <= '0;
            s1_qm    <= '0;
            s1_n1    <= '0;
        end else begin
            s1_mode  <= mode_i;
            s1_ctrl  <= ctrl_i;
            s1_terc4 <= terc4_i;
            s1_qm    <= qm_d;
            s1_n1    <= n1_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_o <= {CHANNELS{CTRL_00}};
            cnt_q  <= '0;
        end else begin
            data_o <= sym_d;
            cnt_q  <= cnt_d;
        end
    end

    assign disp_o = cnt_q;

endmodule
